// File: rtl/sd_resp_rx_gen.sv
// SD CMD-line response receiver: start-bit wait with NCR timeout,
// 48/136-bit capture, tx/CRC7/end-bit checks and a done pulse.
module sd_resp_rx_gen #(
  parameter int LONG_LEN       = 136,
  parameter int SHORT_LEN      = 48,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bit_en,
  input  logic                start,
  input  logic                abort,
  input  logic                long_resp,
  input  logic                crc_check_en,
  input  logic                sd_cmd,
  output logic [LONG_LEN-1:0] response,
  output logic [5:0]          cmd_index,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic                tx_err,
  output logic                crc_err,
  output logic                end_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE
  } state_t;

  localparam logic [CNT_W-1:0] LEN_L    = CNT_W'(LONG_LEN);
  localparam logic [CNT_W-1:0] LEN_S    = CNT_W'(SHORT_LEN);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TX_POS   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CRC_LO   = CNT_W'(9);
  localparam logic [CNT_W-1:0] CRC_TAIL = CNT_W'(8);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    len, pos, tcnt, k;
  logic                is_long, crc_en;
  logic [6:0]          crc, crc_nx;
  logic                fb, last, crc_in;
  logic                accept, got_start, idle_hi, tmo, sample;
  logic [LONG_LEN-1:0] shifted;

  // k is the 1-based frame position of the bit being sampled now
  assign k       = pos + ONE;
  assign last    = (k == len);
  assign crc_in  = (k <= len - CRC_TAIL) && (!is_long || k >= CRC_LO);
  assign shifted = {response[LONG_LEN-2:0], sd_cmd};
  assign fb      = crc[6] ^ sd_cmd;
  assign crc_nx  = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    got_start = 1'b0;
    idle_hi   = 1'b0;
    tmo       = 1'b0;
    sample    = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !done) begin
            accept   = 1'b1;
            state_nx = WAIT_START;
          end
        end
        WAIT_START: begin
          if (bit_en) begin
            if (!sd_cmd) begin
              got_start = 1'b1;
              state_nx  = RECEIVE;
            end else begin
              idle_hi = 1'b1;
              if (tcnt == TMO_LAST) begin
                tmo      = 1'b1;
                state_nx = IDLE;
              end
            end
          end
        end
        RECEIVE: begin
          if (bit_en) begin
            sample = 1'b1;
            if (last) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      response    <= '0;
      cmd_index   <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      tx_err      <= 1'b0;
      crc_err     <= 1'b0;
      end_err     <= 1'b0;
      len         <= '0;
      pos         <= '0;
      tcnt        <= '0;
      crc         <= '0;
      is_long     <= 1'b0;
      crc_en      <= 1'b0;
    end else begin
      done <= tmo | (sample & last);
      if (accept) begin
        response    <= '0;
        timeout_err <= 1'b0;
        tx_err      <= 1'b0;
        crc_err     <= 1'b0;
        end_err     <= 1'b0;
        tcnt        <= '0;
        crc         <= '0;
        pos         <= '0;
        is_long     <= long_resp;
        crc_en      <= crc_check_en;
        len         <= long_resp ? LEN_L : LEN_S;
      end
      // start bit is 0 into a zero CRC, so the CRC needs no update here
      if (got_start) begin
        response <= shifted;
        pos      <= ONE;
      end
      if (idle_hi) tcnt <= tcnt + ONE;
      if (tmo)     timeout_err <= 1'b1;
      if (sample) begin
        response <= shifted;
        pos      <= k;
        if (crc_in) crc <= crc_nx;
        if (k == TX_POS && sd_cmd) tx_err <= 1'b1;
        if (last) begin
          if (!sd_cmd) end_err <= 1'b1;
          crc_err   <= crc_en && (crc != response[6:0]);
          cmd_index <= is_long ? 6'h3F
                               : shifted[SHORT_LEN-3 -: 6];
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_resp_rx_gen.sv
// Scoreboard bench for sd_resp_rx_gen: directed SD responses,
// monitor pops expected results on every done pulse.
module tb_sd_resp_rx_gen;

  localparam int LL = 136;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bit_en = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          long_resp = 1'b0;
  logic          crc_check_en = 1'b0;
  logic          sd_cmd = 1'b1;
  logic [LL-1:0] response;
  logic [5:0]    cmd_index;
  logic          busy, done;
  logic          timeout_err, tx_err, crc_err, end_err;

  typedef struct packed {
    logic [LL-1:0] resp;
    logic [5:0]    idx;
    logic [3:0]    flg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   end_cyc = 0;

  localparam logic [47:0]  R7   = 48'h08000001AA13;
  localparam logic [47:0]  C0   = 48'h400000000095;
  localparam logic [47:0]  C0E  = 48'h400000000094;
  localparam logic [119:0] PAY  = 120'h123456789ABCDEF00F1E2D3C4B5A69;

  logic [LL-1:0] r2, r2b;

  sd_resp_rx_gen dut (
    .clk         (clk),
    .reset       (reset),
    .bit_en      (bit_en),
    .start       (start),
    .abort       (abort),
    .long_resp   (long_resp),
    .crc_check_en(crc_check_en),
    .sd_cmd      (sd_cmd),
    .response    (response),
    .cmd_index   (cmd_index),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .tx_err      (tx_err),
    .crc_err     (crc_err),
    .end_err     (end_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [LL-1:0] act,
                     input logic [LL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [LL-1:0] d,
                                     input int n);
    logic [6:0] c;
    logic       f;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      f = c[6] ^ d[i];
      c = {c[5:0], 1'b0};
      if (f) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("response", response, mon_e.resp);
        chk("cmd_index", cmd_index, mon_e.idx);
        chk("flags_tmo_tx_crc_end",
            {timeout_err, tx_err, crc_err, end_err}, mon_e.flg);
        chk("done_latency", cyc, end_cyc + 1);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic expect_done(input logic [LL-1:0] r,
                             input logic [5:0] idx,
                             input logic [3:0] flg);
    exp_t e;
    e.resp = r;
    e.idx  = idx;
    e.flg  = flg;
    sb.push_back(e);
  endtask

  task automatic strobe(input logic b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1 bit_en = 1'b0;
    end
    @(posedge clk);
    #1 sd_cmd = b;
    bit_en  = 1'b1;
    end_cyc = cyc;
  endtask

  task automatic run_frame(input logic [LL-1:0] f, input int n,
                           input int cnt, input logic lng,
                           input logic ce, input int gap,
                           input int pre, input logic sad);
    @(posedge clk);
    #1 start = 1'b1;
    long_resp    = lng;
    crc_check_en = ce;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < pre; i++) strobe(1'b1, gap);
    for (int i = 0; i < cnt; i++) strobe(f[n-1-i], gap);
    @(posedge clk);
    #1 bit_en = 1'b0;
    sd_cmd = 1'b1;
    start  = sad;
    @(posedge clk);
    #1 start = 1'b0;
    if (sad) chk("start_in_done_ignored", busy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_response"}, response, 0);
    chk({tag, "_cmd_index"}, cmd_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_flags"},
        {timeout_err, tx_err, crc_err, end_err}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    r2  = {8'h3F, PAY, crc7({16'h0, PAY}, 120), 1'b1};
    r2b = r2 ^ (136'h1 << 60);

    #22;
    chk_cleared("reset");
    @(negedge clk) reset = 1'b0;

    expect_done({88'h0, R7}, 6'd8, 4'b0000);
    run_frame({88'h0, R7}, 48, 48, 1'b0, 1'b1, 0, 0, 1'b1);
    drain();

    expect_done({88'h0, R7}, 6'd8, 4'b0000);
    run_frame({88'h0, R7}, 48, 48, 1'b0, 1'b1, 2, 5, 1'b0);
    drain();

    expect_done({88'h0, C0}, 6'd0, 4'b0100);
    run_frame({88'h0, C0}, 48, 48, 1'b0, 1'b1, 0, 0, 1'b0);
    drain();

    expect_done({88'h0, C0E}, 6'd0, 4'b0101);
    run_frame({88'h0, C0E}, 48, 48, 1'b0, 1'b1, 0, 0, 1'b0);
    drain();

    expect_done(r2, 6'h3F, 4'b0000);
    run_frame(r2, 136, 136, 1'b1, 1'b1, 0, 0, 1'b0);
    drain();

    expect_done(r2b, 6'h3F, 4'b0010);
    run_frame(r2b, 136, 136, 1'b1, 1'b1, 0, 0, 1'b0);
    drain();

    // NCR timeout: cmd_index keeps its previous value
    expect_done('0, 6'h3F, 4'b1000);
    run_frame('0, 0, 0, 1'b0, 1'b1, 0, 64, 1'b0);
    drain();

    expect_done({88'h0, R7}, 6'd8, 4'b0000);
    run_frame({88'h0, R7}, 48, 48, 1'b0, 1'b1, 0, 63, 1'b0);
    drain();

    run_frame({88'h0, R7}, 48, 20, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("busy_before_abort", busy, 1);
    @(posedge clk);
    #1 abort = 1'b1;
    bit_en = 1'b1;
    sd_cmd = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    bit_en = 1'b0;
    sd_cmd = 1'b1;
    chk("busy_after_abort", busy, 0);
    chk("response_held_abort", response, 136'h08000);
    chk("flags_held_abort",
        {timeout_err, tx_err, crc_err, end_err}, 0);
    repeat (6) @(posedge clk);

    expect_done({88'h0, R7}, 6'd8, 4'b0000);
    run_frame({88'h0, R7}, 48, 48, 1'b0, 1'b1, 0, 0, 1'b0);
    drain();

    run_frame(r2, 136, 60, 1'b1, 1'b1, 0, 0, 1'b0);
    chk("busy_mid_r2", busy, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_cleared("async_reset");
    @(negedge clk) reset = 1'b0;

    expect_done({88'h0, R7}, 6'd8, 4'b0000);
    run_frame({88'h0, R7}, 48, 48, 1'b0, 1'b1, 0, 0, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
